// File: rtl/pario_pkg.sv
// rtl/pario_pkg.sv - shared types and default timing for the parallel pad link
//
// Purpose: state encoding of the transmitter FSM, bus width and the default
// handshake timing shared by the transmitter, the receiver and the top level.
// Ports: none (package).

package pario_pkg;

   localparam int PARIO_WIDTH     = 14;
   localparam int PARIO_DEPTH     = 4;
   localparam int PARIO_SETUP_CYC = 2;
   localparam int PARIO_HOLD_CYC  = 1;
   localparam int PARIO_TIMEOUT   = 255;

   // Width of the setup/hold phase counter.
   localparam int PARIO_CNT_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_ACK_LOW,
      ST_HOLD
   } pario_state_t;

endpackage

// File: rtl/pario_fifo.sv
// rtl/pario_fifo.sv - synchronous show-ahead word FIFO with full/empty
//
// Purpose: buffers words from core logic ahead of the pad transmitter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data (ignored while full)
//   push_data   word to store
//   pop         remove the head word (ignored while empty)
//   pop_data    head word, valid whenever empty is low
//   full        DEPTH words stored
//   empty       no words stored

module pario_fifo #(
   parameter int WIDTH = 14,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == CNT_FULL);
   assign empty    = (count_q == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/pario_tx.sv
// rtl/pario_tx.sv - core-side transmitter for the bidirectional pad bus
//
// Purpose: buffers core words and sends each one over the pads with a
// 4-phase strobe/acknowledge handshake, with per-edge acknowledge timeout.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_data       word to send
//   in_valid      in_data valid
//   in_ready      FIFO can accept a word
//   enable        permits new transfers to start
//   err_clr       single-cycle pulse, clears timeout_err
//   io_o          pad drive data
//   io_oe         pad output enable, all bits identical
//   stb           strobe to the chip_out pad
//   ack           acknowledge from the chip_in pad, asynchronous to clk
//   busy          FSM is not idle
//   timeout_err   sticky acknowledge-timeout flag
//   sent_count    completed transfers, wraps at 16 bits

module pario_tx
   import pario_pkg::*;
#(
   parameter int WIDTH     = PARIO_WIDTH,
   parameter int DEPTH     = PARIO_DEPTH,
   parameter int SETUP_CYC = PARIO_SETUP_CYC,
   parameter int HOLD_CYC  = PARIO_HOLD_CYC,
   parameter int TIMEOUT   = PARIO_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             enable,
   input  logic             err_clr,
   output logic [WIDTH-1:0] io_o,
   output logic [WIDTH-1:0] io_oe,
   output logic             stb,
   input  logic             ack,
   output logic             busy,
   output logic             timeout_err,
   output logic [15:0]      sent_count
);

   localparam logic [PARIO_CNT_W-1:0] CNT_ONE    = PARIO_CNT_W'(1);
   localparam logic [PARIO_CNT_W-1:0] SETUP_LOAD = PARIO_CNT_W'(SETUP_CYC - 1);
   localparam logic [PARIO_CNT_W-1:0] HOLD_LOAD  = PARIO_CNT_W'(HOLD_CYC - 1);
   // Checked before incrementing, so the abort lands exactly TIMEOUT cycles
   // after entering STROBE or ACK_LOW.
   localparam logic [7:0]             TIMER_LAST = 8'(TIMEOUT - 1);

   pario_state_t            state_q, state_d;
   logic [PARIO_CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]              timer_q, timer_d;
   logic [WIDTH-1:0]        io_o_q, io_o_d;
   logic                    io_oe_q, io_oe_d;
   logic                    stb_q, stb_d;
   logic                    err_q, err_d;
   logic [15:0]             sent_q, sent_d;
   logic                    ack_meta_q, ack_meta_d;
   logic                    ack_s_q, ack_s_d;

   logic                    fifo_pop;
   logic [WIDTH-1:0]        fifo_data;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    start_ok;
   logic                    cnt_zero;
   logic                    timer_exp;
   logic                    timeout_hit;

   pario_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid),
      .push_data (in_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign in_ready    = !fifo_full;
   assign io_o        = io_o_q;
   assign io_oe       = {WIDTH{io_oe_q}};
   assign stb         = stb_q;
   assign busy        = (state_q != ST_IDLE);
   assign timeout_err = err_q;
   assign sent_count  = sent_q;

   // A pending timeout error blocks new words until software clears it.
   assign start_ok  = enable && !fifo_empty && !err_q;
   assign cnt_zero  = (cnt_q == '0);
   assign timer_exp = (timer_q == TIMER_LAST);

   // Two-flop synchroniser for the asynchronous acknowledge.
   always_comb begin
      ack_meta_d = ack;
      ack_s_d    = ack_meta_q;
   end

   // State register and datapath flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         timer_q    <= '0;
         io_o_q     <= '0;
         io_oe_q    <= 1'b0;
         stb_q      <= 1'b0;
         err_q      <= 1'b0;
         sent_q     <= '0;
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         io_o_q     <= io_o_d;
         io_oe_q    <= io_oe_d;
         stb_q      <= stb_d;
         err_q      <= err_d;
         sent_q     <= sent_d;
         ack_meta_q <= ack_meta_d;
         ack_s_q    <= ack_s_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start_ok) state_d = ST_SETUP;
         ST_SETUP:   if (cnt_zero) state_d = ST_STROBE;
         ST_STROBE: begin
            if (ack_s_q)        state_d = ST_ACK_LOW;
            else if (timer_exp) state_d = ST_IDLE;
         end
         ST_ACK_LOW: begin
            if (!ack_s_q)       state_d = ST_HOLD;
            else if (timer_exp) state_d = ST_IDLE;
         end
         ST_HOLD:    if (cnt_zero) state_d = start_ok ? ST_SETUP : ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Output and datapath logic.
   always_comb begin
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      io_o_d      = io_o_q;
      io_oe_d     = io_oe_q;
      stb_d       = stb_q;
      err_d       = err_q;
      sent_d      = sent_q;
      fifo_pop    = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               fifo_pop = 1'b1;
               io_o_d   = fifo_data;
               io_oe_d  = 1'b1;
               cnt_d    = SETUP_LOAD;
            end
         end
         ST_SETUP: begin
            if (cnt_zero) begin
               stb_d   = 1'b1;
               timer_d = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_STROBE: begin
            if (ack_s_q) begin
               stb_d   = 1'b0;
               timer_d = '0;
            end else if (timer_exp) begin
               timeout_hit = 1'b1;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         ST_ACK_LOW: begin
            if (!ack_s_q) begin
               sent_d = sent_q + 16'd1;
               cnt_d  = HOLD_LOAD;
            end else if (timer_exp) begin
               timeout_hit = 1'b1;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               if (start_ok) begin
                  // Back-to-back: the bus stays driven, only the data changes.
                  fifo_pop = 1'b1;
                  io_o_d   = fifo_data;
                  cnt_d    = SETUP_LOAD;
               end else begin
                  io_oe_d = 1'b0;
                  io_o_d  = '0;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            io_oe_d = 1'b0;
            stb_d   = 1'b0;
         end
      endcase
      if (err_clr) begin
         err_d = 1'b0;
      end
      // Abort releases the bus and drops the word; the set beats a clear.
      if (timeout_hit) begin
         stb_d   = 1'b0;
         io_oe_d = 1'b0;
         io_o_d  = '0;
         err_d   = 1'b1;
      end
   end

endmodule

// File: tb/tb_pario_tx.sv
// tb/tb_pario_tx.sv - directed self-checking bench for pario_tx

module tb_pario_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [13:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        enable = 1'b0;
   logic        err_clr = 1'b0;
   logic [13:0] io_o;
   logic [13:0] io_oe;
   logic        stb;
   logic        ack;
   logic        busy;
   logic        timeout_err;
   logic [15:0] sent_count;

   logic        resp_en = 1'b0;
   logic [13:0] rx_q [$];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   pario_tx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .enable      (enable),
      .err_clr     (err_clr),
      .io_o        (io_o),
      .io_oe       (io_oe),
      .stb         (stb),
      .ack         (ack),
      .busy        (busy),
      .timeout_err (timeout_err),
      .sent_count  (sent_count)
   );

   // Far-end responder: raises ack 3 cycles after stb rises, drops it
   // 3 cycles after stb falls, and records the word on the bus.
   initial begin
      int rise_n;
      int fall_n;
      ack    = 1'b0;
      rise_n = 0;
      fall_n = 0;
      forever begin
         @(negedge clk);
         if (!resp_en || !rst_n) begin
            ack    = 1'b0;
            rise_n = 0;
            fall_n = 0;
         end else if (!ack) begin
            if (stb) begin
               rise_n++;
               if (rise_n == 3) begin
                  ack    = 1'b1;
                  rise_n = 0;
                  rx_q.push_back(io_o);
               end
            end else begin
               rise_n = 0;
            end
         end else begin
            if (!stb) begin
               fall_n++;
               if (fall_n == 3) begin
                  ack    = 1'b0;
                  fall_n = 0;
               end
            end else begin
               fall_n = 0;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [13:0] d);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      err_clr  = 1'b0;
      enable   = 1'b0;
      resp_en  = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      rx_q.delete();
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while ((busy || io_oe != 14'h0) && n < limit) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_stb(input string tag, input int limit);
      int n = 0;
      while (!stb && n < limit) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, stb}, 32'd1);
   endtask

   function automatic logic [31:0] rx_at(input int k);
      if (k < rx_q.size()) return {18'd0, rx_q[k]};
      return 32'hDEAD;
   endfunction

   initial begin
      int n;
      int gap;
      logic [13:0] words [4];
      words[0] = 14'h0001;
      words[1] = 14'h0002;
      words[2] = 14'h0004;
      words[3] = 14'h0008;

      // Reset state
      do_reset();
      chk("rst_io_o", io_o, 0);
      chk("rst_io_oe", io_oe, 0);
      chk("rst_stb", stb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_sent", sent_count, 0);
      chk("rst_in_ready", in_ready, 1);

      // Single word
      enable  = 1'b1;
      resp_en = 1'b1;
      push(14'h2A5A);
      chk("t1_oe_pre", io_oe, 0);
      tick();
      chk("t1_oe", io_oe, 32'h3FFF);
      chk("t1_io_o", io_o, 32'h2A5A);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_stb_setup", stb, 0);
      tick();
      chk("t1_stb_rise", stb, 1);
      wait_idle("t1_idle", 100);
      chk("t1_sent", sent_count, 1);
      chk("t1_oe_end", io_oe, 0);
      chk("t1_io_o_end", io_o, 0);
      chk("t1_rx_n", rx_q.size(), 1);
      chk("t1_rx0", rx_at(0), 32'h2A5A);

      // Back-to-back from a full FIFO
      do_reset();
      resp_en = 1'b1;
      for (int k = 0; k < 4; k++) push(words[k]);
      chk("t2_full", in_ready, 0);
      chk("t2_idle_gated", busy, 0);
      enable = 1'b1;
      tick();
      n   = 0;
      gap = 0;
      while (busy && n < 400) begin
         if (io_oe !== 14'h3FFF) gap++;
         tick();
         n++;
      end
      chk("t2_done", busy, 0);
      chk("t2_oe_gap", gap, 0);
      chk("t2_sent", sent_count, 4);
      chk("t2_rx_n", rx_q.size(), 4);
      for (int k = 0; k < 4; k++) chk($sformatf("t2_rx%0d", k), rx_at(k), {18'd0, words[k]});
      chk("t2_in_ready", in_ready, 1);

      // Acknowledge timeout
      do_reset();
      enable = 1'b1;
      push(14'h1555);
      wait_stb("t3_stb", 20);
      n = 0;
      while (stb && n < 300) begin
         tick();
         n++;
      end
      chk("t3_stb_len", n, 255);
      chk("t3_oe", io_oe, 0);
      chk("t3_io_o", io_o, 0);
      chk("t3_err", timeout_err, 1);
      chk("t3_sent", sent_count, 0);
      chk("t3_busy", busy, 0);
      push(14'h0AAA);
      repeat (30) tick();
      chk("t3_held_busy", busy, 0);
      chk("t3_held_oe", io_oe, 0);
      chk("t3_held_err", timeout_err, 1);
      resp_en = 1'b1;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t3_err_clr", timeout_err, 0);
      tick();
      chk("t3_restart", busy, 1);
      wait_idle("t3_idle", 100);
      chk("t3_sent2", sent_count, 1);
      chk("t3_rx_n", rx_q.size(), 1);
      chk("t3_rx0", rx_at(0), 32'h0AAA);

      // Enable gating
      do_reset();
      resp_en = 1'b1;
      push(14'h0FFF);
      gap = 0;
      repeat (20) begin
         if (busy || io_oe != 14'h0) gap++;
         tick();
      end
      chk("t4_gated", gap, 0);
      enable = 1'b1;
      tick();
      chk("t4_busy", busy, 1);
      chk("t4_oe", io_oe, 32'h3FFF);
      chk("t4_io_o", io_o, 32'h0FFF);
      wait_idle("t4_idle", 100);
      chk("t4_sent", sent_count, 1);

      // Reset mid-transfer
      do_reset();
      enable  = 1'b1;
      resp_en = 1'b1;
      push(14'h0111);
      tick();
      wait_idle("t5_pre_idle", 100);
      chk("t5_pre_sent", sent_count, 1);
      resp_en = 1'b0;
      push(14'h0123);
      push(14'h0456);
      wait_stb("t5_stb", 20);
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_stb", stb, 0);
      chk("t5_oe", io_oe, 0);
      chk("t5_busy", busy, 0);
      chk("t5_sent", sent_count, 0);
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("t5_empty_busy", busy, 0);
      chk("t5_empty_oe", io_oe, 0);
      chk("t5_in_ready", in_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pario_tx.md
Name: pario_tx

Overview:
- Core-side transmitter for the 14-bit bidirectional pad bus. It is the sending end of the parallel link whose receiving end registers the chip_in pads.
- Buffers words from core logic and drives them onto the inout pads through the pad output and output-enable nets.
- Frames each word with a 4-phase strobe/acknowledge handshake: strobe goes out on a chip_out pad, acknowledge comes back on a chip_in pad.
- Sits between core logic and the pad ring inside the top level.

Parameters:
- WIDTH, 14, data bus width (one bit per inout pad)
- DEPTH, 4, input FIFO depth in words (power of two, at least 2)
- SETUP_CYC, 2, cycles data is driven before strobe rises (at least 1)
- HOLD_CYC, 1, cycles data is held after acknowledge falls (at least 1)
- TIMEOUT, 255, maximum cycles to wait for each acknowledge edge

Ports:
- clk  in  1  system clock, from the clk pad
- rst_n  in  1  asynchronous active-low reset
- in_data  in  WIDTH  word to send
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept a word
- enable  in  1  permits new transfers to start
- err_clr  in  1  single-cycle pulse, clears timeout_err
- io_o  out  WIDTH  pad drive data (c2p)
- io_oe  out  WIDTH  pad output enable (c2p_en); all bits identical
- stb  out  1  strobe to the chip_out pad
- ack  in  1  acknowledge from the chip_in pad; asynchronous to clk
- busy  out  1  FSM is not in IDLE
- timeout_err  out  1  sticky timeout flag
- sent_count  out  16  count of completed transfers

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - io_o=0, io_oe=0, stb=0, busy=0, timeout_err=0, sent_count=0.
  - FIFO empty, FSM in IDLE, ack synchroniser cleared to 0.
- ack passes through a 2-flop synchroniser; all decisions use the synchronised ack_s (2-cycle latency).
- FIFO:
  - in_ready = !full; push on in_valid && in_ready.
  - Pop happens only when a word is loaded in IDLE or at the end of HOLD.
  - A simultaneous push and pop while full is not allowed, because in_ready is 0.
  - A push and pop in the same cycle at any other occupancy keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, STROBE, ACK_LOW, HOLD.
  - IDLE: if enable && !empty, pop the word into a data register, set io_o=word and io_oe=all ones, load cnt=SETUP_CYC-1, go to SETUP. First drive appears 1 cycle after the pop.
  - SETUP: decrement cnt; at cnt==0 set stb=1, clear the timer, go to STROBE.
  - STROBE: when ack_s==1, set stb=0, clear the timer, go to ACK_LOW.
  - ACK_LOW: when ack_s==0, increment sent_count (wrapping at 16 bits), load cnt=HOLD_CYC-1, go to HOLD.
  - HOLD: at cnt==0:
    - if enable && !empty, pop the next word, keep io_oe asserted, update io_o, go to SETUP (back-to-back, no bus release);
    - otherwise set io_oe=0 and io_o=0, go to IDLE.
- Timeout:
  - An 8-bit timer runs in STROBE and ACK_LOW.
  - When the timer reaches TIMEOUT without the expected ack_s edge: set stb=0, io_oe=0, io_o=0, set timeout_err, go to IDLE. The word is dropped and sent_count is not incremented.
  - While timeout_err=1, no new transfer starts. err_clr clears it. If err_clr and a new timeout occur in the same cycle, the set wins.
- enable deasserted mid-transfer: the in-flight word completes; only the start of the next word is gated.
- ack already high in IDLE or SETUP: ignored. STROBE then sees ack_s==1 one cycle after stb rises.
- busy = (state != IDLE).

Decomposition:
- Shared package pario_pkg holds:
  - the state enum typedef;
  - PARIO_WIDTH=14;
  - the default timing constants, shared with the receiver side and the top level.
- One sub-module, pario_fifo (synchronous FIFO with full/empty, parameterised by WIDTH and DEPTH).
- The 2-flop synchroniser is written inline.

Test Plan:
- Reset then a single word: push 14'h2A5A, with a bench responder raising ack 3 cycles after stb and dropping it 3 cycles after stb falls. Required:
  - io_oe=3FFF one cycle after the push;
  - stb rises 2 cycles later;
  - sent_count=1;
  - io_oe=0 after HOLD.
- Back-to-back: push 4 words 0001, 0002, 0004, 0008 to fill the FIFO. Required:
  - in_ready=0 after the 4th push;
  - io_oe stays 3FFF across all transfers;
  - responder sees the words in order;
  - sent_count=4.
- Timeout: push 1555 with no ack response. Required:
  - stb falls after 255 cycles in STROBE;
  - io_oe=0 and timeout_err=1;
  - sent_count unchanged;
  - a second pushed word is not sent until err_clr is pulsed.
- Enable gating: with enable=0, push 0FFF. Required:
  - busy=0 and io_oe=0 for 20 cycles;
  - raising enable starts the transfer the next cycle.
- Reset mid-transfer: assert rst_n=0 while in STROBE. Required:
  - stb, io_oe, busy and sent_count become 0 immediately (asynchronous);
  - FIFO empty after release.
